// File: rtl/hs_elastic_fifo_if.sv
// Handshake bundle for hs_elastic_fifo: upstream pull port, downstream ack port
// and the occupancy/throughput status the FIFO exposes.
interface hs_elastic_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
);
  logic                  up_req;
  logic                  up_ack;
  logic [DATA_WIDTH-1:0] up_din;
  logic                  dn_req;
  logic                  dn_ack;
  logic [DATA_WIDTH-1:0] dn_dout;
  logic [ADDR_WIDTH:0]   level;
  logic [31:0]           count_in;
  logic [31:0]           count_out;
  logic                  proto_err;

  modport master (
    output up_req,
    input  up_ack,
    input  up_din,
    input  dn_req,
    output dn_ack,
    output dn_dout,
    output level,
    output count_in,
    output count_out,
    output proto_err
  );

  modport slave (
    input  up_req,
    output up_ack,
    output up_din,
    output dn_req,
    input  dn_ack,
    input  dn_dout,
    input  level,
    input  count_in,
    input  count_out,
    input  proto_err
  );
endinterface

// File: rtl/hs_elastic_fifo.sv
// Elastic req/ack buffer: pulls words from upstream one request at a time and
// answers downstream requests with single-cycle acks, counting transfers.
module hs_elastic_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  hs_elastic_fifo_if.master bus
);

  localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LVL_ONE    = (ADDR_WIDTH + 1)'(1'b1);
  localparam logic [ADDR_WIDTH:0]   LVL_ZERO   = (ADDR_WIDTH + 1)'(1'b0);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1'b1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  up_req_q,    up_req_d;
  logic                  dn_ack_q,    dn_ack_d;
  logic [DATA_WIDTH-1:0] dn_dout_q,   dn_dout_d;
  logic [ADDR_WIDTH:0]   level_q,     level_d;
  logic [ADDR_WIDTH-1:0] wp_q,        wp_d;
  logic [ADDR_WIDTH-1:0] rp_q,        rp_d;
  logic [31:0]           count_in_q,  count_in_d;
  logic [31:0]           count_out_q, count_out_d;
  logic                  proto_err_q, proto_err_d;

  logic push_s;
  logic pop_s;
  logic spurious_s;

  // The pop looks at pre-edge level, so a word written this edge is never read this edge.
  assign push_s     = bus.up_ack & up_req_q;
  assign spurious_s = bus.up_ack & ~up_req_q;
  assign pop_s      = bus.dn_req & ~dn_ack_q & (level_q != LVL_ZERO);

  // Next-state logic for both handshake sides, occupancy and counters.
  always_comb begin
    up_req_d    = up_req_q;
    dn_ack_d    = 1'b0;
    dn_dout_d   = dn_dout_q;
    level_d     = level_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    count_in_d  = count_in_q;
    count_out_d = count_out_q;
    proto_err_d = proto_err_q | spurious_s;

    if (push_s) begin
      up_req_d   = 1'b0;
      wp_d       = wp_q + PTR_ONE;
      count_in_d = count_in_q + 32'd1;
    end else if (!up_req_q && (level_q < FULL_LEVEL)) begin
      up_req_d = 1'b1;
    end else begin
      up_req_d = up_req_q;
    end

    if (pop_s) begin
      dn_ack_d    = 1'b1;
      dn_dout_d   = mem_q[rp_q];
      rp_d        = rp_q + PTR_ONE;
      count_out_d = count_out_q + 32'd1;
    end else begin
      dn_ack_d  = 1'b0;
      dn_dout_d = dn_dout_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_req_q    <= 1'b0;
      dn_ack_q    <= 1'b0;
      dn_dout_q   <= '0;
      level_q     <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      count_in_q  <= 32'd0;
      count_out_q <= 32'd0;
      proto_err_q <= 1'b0;
    end else begin
      up_req_q    <= up_req_d;
      dn_ack_q    <= dn_ack_d;
      dn_dout_q   <= dn_dout_d;
      level_q     <= level_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_in_q  <= count_in_d;
      count_out_q <= count_out_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wp_q] <= bus.up_din;
    end
  end

  assign bus.up_req    = up_req_q;
  assign bus.dn_ack    = dn_ack_q;
  assign bus.dn_dout   = dn_dout_q;
  assign bus.level     = level_q;
  assign bus.count_in  = count_in_q;
  assign bus.count_out = count_out_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_hs_elastic_fifo.sv
// Directed bench for hs_elastic_fifo: a cycle table for reset and single-word
// traffic, then hand-written fill, streaming, spurious-ack and mid-run reset cases.
module tb_hs_elastic_fifo;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  hs_elastic_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) bus ();

  hs_elastic_fifo #(.DATA_WIDTH(32), .DEPTH(4), .ADDR_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        up_ack;
    logic [31:0] up_din;
    logic        dn_req;
    logic        e_up_req;
    logic        e_dn_ack;
    logic [31:0] e_dout;
    logic [2:0]  e_level;
    logic [31:0] e_cin;
    logic [31:0] e_cout;
    logic        e_perr;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.up_ack = 1'b0;
    bus.dn_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("reset_up_req_rise", bus.up_req, 1'b1);
  endtask

  // Acks n upstream requests with base, base+1, ... while dn_req stays low.
  task automatic fill(input int n, input logic [31:0] base);
    int words;
    words = 0;
    for (int c = 0; c < 40 && words < n; c++) begin
      bus.up_ack = bus.up_req;
      bus.up_din = base + 32'(words);
      if (bus.up_req) words++;
      tick();
    end
    bus.up_ack = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    bus.up_ack = 1'b0;
    bus.up_din = 32'h0;
    bus.dn_req = 1'b0;

    vt[0]  = '{1'b1, 1'b1, 32'hBEEF, 1'b1,  1'b0, 1'b0, 32'h00, 3'd0, 32'd0, 32'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 32'hCAFE, 1'b1,  1'b0, 1'b0, 32'h00, 3'd0, 32'd0, 32'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'h0000, 1'b0,  1'b1, 1'b0, 32'h00, 3'd0, 32'd0, 32'd0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 32'h0011, 1'b1,  1'b0, 1'b0, 32'h00, 3'd1, 32'd1, 32'd0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 32'h0000, 1'b1,  1'b1, 1'b1, 32'h11, 3'd0, 32'd1, 32'd1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'h0000, 1'b1,  1'b1, 1'b0, 32'h11, 3'd0, 32'd1, 32'd1, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 32'h0022, 1'b0,  1'b0, 1'b0, 32'h11, 3'd1, 32'd2, 32'd1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 32'h0000, 1'b1,  1'b1, 1'b1, 32'h22, 3'd0, 32'd2, 32'd2, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 32'h0044, 1'b1,  1'b0, 1'b0, 32'h22, 3'd1, 32'd3, 32'd2, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 32'h0000, 1'b1,  1'b1, 1'b1, 32'h44, 3'd0, 32'd3, 32'd3, 1'b0};
    vt[10] = '{1'b0, 1'b1, 32'h0055, 1'b1,  1'b0, 1'b0, 32'h44, 3'd1, 32'd4, 32'd3, 1'b0};
    vt[11] = '{1'b0, 1'b0, 32'h0000, 1'b0,  1'b1, 1'b0, 32'h44, 3'd1, 32'd4, 32'd3, 1'b0};
    vt[12] = '{1'b0, 1'b1, 32'h0066, 1'b1,  1'b0, 1'b1, 32'h55, 3'd1, 32'd5, 32'd4, 1'b0};
    vt[13] = '{1'b0, 1'b0, 32'h0000, 1'b1,  1'b1, 1'b0, 32'h55, 3'd1, 32'd5, 32'd4, 1'b0};
    vt[14] = '{1'b0, 1'b0, 32'h0000, 1'b1,  1'b1, 1'b1, 32'h66, 3'd0, 32'd5, 32'd5, 1'b0};
    vt[15] = '{1'b0, 1'b0, 32'h0000, 1'b1,  1'b1, 1'b0, 32'h66, 3'd0, 32'd5, 32'd5, 1'b0};

    // Reset, single-word transfers, push/pop on one edge, empty hold-off.
    for (int i = 0; i < 16; i++) begin
      rst        = vt[i].rst;
      bus.up_ack = vt[i].up_ack;
      bus.up_din = vt[i].up_din;
      bus.dn_req = vt[i].dn_req;
      tick();
      chk($sformatf("vec%0d_up_req", i),    bus.up_req,    vt[i].e_up_req);
      chk($sformatf("vec%0d_dn_ack", i),    bus.dn_ack,    vt[i].e_dn_ack);
      chk($sformatf("vec%0d_dn_dout", i),   bus.dn_dout,   vt[i].e_dout);
      chk($sformatf("vec%0d_level", i),     bus.level,     vt[i].e_level);
      chk($sformatf("vec%0d_count_in", i),  bus.count_in,  vt[i].e_cin);
      chk($sformatf("vec%0d_count_out", i), bus.count_out, vt[i].e_cout);
      chk($sformatf("vec%0d_proto_err", i), bus.proto_err, vt[i].e_perr);
    end

    // Fill to DEPTH, hold, then drain on alternate cycles.
    begin
      logic seen_req;
      do_reset();
      fill(4, 32'hA0);
      chk("fill_level", bus.level, 3'd4);
      chk("fill_up_req", bus.up_req, 1'b0);
      seen_req = 1'b0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (bus.up_req) seen_req = 1'b1;
      end
      chk("full_up_req_held_low", seen_req, 1'b0);
      bus.dn_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
        tick();
        chk($sformatf("drain%0d_dn_ack", k), bus.dn_ack, (k % 2 == 0) ? 1'b1 : 1'b0);
        chk($sformatf("drain%0d_dn_dout", k), bus.dn_dout, 32'hA0 + 32'(k / 2));
        chk($sformatf("drain%0d_level", k), bus.level, 3'(3 - k / 2));
        chk($sformatf("drain%0d_up_req", k), bus.up_req, (k == 0) ? 1'b0 : 1'b1);
      end
      bus.dn_req = 1'b0;
    end

    // Streaming 0..99 through with both sides active.
    begin
      int sent;
      int rcv;
      do_reset();
      sent       = 0;
      rcv        = 0;
      bus.dn_req = 1'b1;
      for (int c = 0; c < 1000 && rcv < 100; c++) begin
        bus.up_ack = bus.up_req && (sent < 100);
        bus.up_din = 32'(sent);
        if (bus.up_ack) sent++;
        tick();
        if (bus.dn_ack) begin
          chk($sformatf("stream_word%0d", rcv), bus.dn_dout, 32'(rcv));
          rcv++;
        end
      end
      bus.up_ack = 1'b0;
      bus.dn_req = 1'b0;
      chk("stream_received", 32'(rcv), 32'd100);
      chk("stream_count_in", bus.count_in, 32'd100);
      chk("stream_count_out", bus.count_out, 32'd100);
      chk("stream_level", bus.level, 3'd0);
    end

    // Spurious ack while no request is outstanding.
    do_reset();
    bus.up_ack = 1'b1;
    bus.up_din = 32'h77;
    tick();
    chk("spur_pre_up_req", bus.up_req, 1'b0);
    bus.up_din = 32'hDEAD;
    tick();
    chk("spur_proto_err", bus.proto_err, 1'b1);
    chk("spur_level", bus.level, 3'd1);
    chk("spur_count_in", bus.count_in, 32'd1);
    bus.up_ack = 1'b0;
    bus.dn_req = 1'b1;
    tick();
    chk("spur_dn_ack", bus.dn_ack, 1'b1);
    chk("spur_dn_dout", bus.dn_dout, 32'h77);
    bus.dn_req = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("spur_err_sticky", bus.proto_err, 1'b1);
    chk("spur_level_end", bus.level, 3'd0);
    rst = 1'b1;
    tick();
    chk("spur_err_cleared", bus.proto_err, 1'b0);
    rst = 1'b0;

    // Reset with three words stored; first delivered word must be new data.
    begin
      logic got;
      do_reset();
      fill(3, 32'h31);
      chk("midrst_level_before", bus.level, 3'd3);
      rst = 1'b1;
      tick();
      chk("midrst_level", bus.level, 3'd0);
      chk("midrst_up_req", bus.up_req, 1'b0);
      chk("midrst_count_in", bus.count_in, 32'd0);
      rst        = 1'b0;
      bus.dn_req = 1'b1;
      got        = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        bus.up_ack = bus.up_req;
        bus.up_din = 32'h55;
        tick();
        if (bus.dn_ack) begin
          chk("midrst_first_word", bus.dn_dout, 32'h55);
          got = 1'b1;
        end
      end
      chk("midrst_delivered", got, 1'b1);
      bus.up_ack = 1'b0;
      bus.dn_req = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
